// File: rtl/npm_toggle_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : npm_toggle_timer_if
// Purpose  : Command / status bundle between an issuing stage and the
//            npm_toggle_timer wait-cycle timer.
// Revision : 1.0  initial release
// ============================================================================
interface npm_toggle_timer_if #(
   parameter int DataWidth = 16
) ();

   logic                 iStart;
   logic [DataWidth-1:0] iNumOfData;
   logic                 iAbort;
   logic                 oReady;
   logic                 oLastStep;
   logic                 oBusy;
   logic [DataWidth-1:0] oElapsed;

   // Issuing stage: drives commands, observes status
   modport master (
      output iStart, iNumOfData, iAbort,
      input  oReady, oLastStep, oBusy, oElapsed
   );

   // Timer: consumes commands, drives status
   modport slave (
      input  iStart, iNumOfData, iAbort,
      output oReady, oLastStep, oBusy, oElapsed
   );

endinterface
`default_nettype wire

// File: rtl/npm_toggle_timer.sv
`default_nettype none
// ============================================================================
// Module   : npm_toggle_timer
// Purpose  : Waits N clock cycles after an accepted command, then holds a
//            completion level until the next command or reset. A running
//            wait can be aborted; elapsed cycles are reported throughout.
// Revision : 1.0  initial release
// ============================================================================
module npm_toggle_timer #(
   parameter int DataWidth = 16
) (
   input  logic                iSystemClock,
   input  logic                iReset,
   npm_toggle_timer_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [DataWidth-1:0] count_q, count_d;
   logic [DataWidth-1:0] elapsed_q, elapsed_d;

   // Ready whenever no wait is in flight; the unused encoding never asserts it
   logic w_ready;
   assign w_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);

   // Next-state, counter and elapsed-cycle computation
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      elapsed_d = elapsed_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            // A command wins over abort outside RUN; abort is meaningless here
            if (bus.iStart) begin
               state_d   = ST_RUN;
               count_d   = bus.iNumOfData;
               elapsed_d = '0;
            end
         end
         ST_RUN: begin
            // Abort wins over a (held) start request while running
            if (bus.iAbort) begin
               state_d = ST_DONE;
               count_d = '0;
            end else if (count_q == '0) begin
               state_d = ST_DONE;
            end else begin
               count_d   = count_q - DataWidth'(1);
               elapsed_d = elapsed_q + DataWidth'(1);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            count_d   = '0;
            elapsed_d = '0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge iSystemClock) begin
      if (iReset) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         elapsed_q <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         elapsed_q <= elapsed_d;
      end
   end

   assign bus.oReady    = w_ready;
   assign bus.oBusy     = (state_q == ST_RUN);
   assign bus.oLastStep = (state_q == ST_DONE);
   assign bus.oElapsed  = elapsed_q;

endmodule
`default_nettype wire

// File: tb/tb_npm_toggle_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_npm_toggle_timer
// Purpose  : Self-checking bench for npm_toggle_timer. A timeline model
//            (acceptance edge, N, optional abort edge) predicts every output
//            each cycle; directed scenarios add literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_npm_toggle_timer;

   localparam int DW = 16;

   logic clk;
   logic rst;

   npm_toggle_timer_if #(.DataWidth(DW)) bus ();

   npm_toggle_timer #(.DataWidth(DW)) dut (
      .iSystemClock (clk),
      .iReset       (rst),
      .bus          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- timeline model ----------------
   // Edges are numbered from simulation start. A wait accepted at edge A with
   // length N finishes at edge A+N+1 unless aborted earlier at edge B, in
   // which case it finishes at B. Elapsed after edge e is e-A while running.
   int unsigned edge_cnt   = 0;
   bit          m_valid    = 0;
   bit          m_have     = 0;
   int unsigned m_acc      = 0;
   int unsigned m_n        = 0;
   bit          m_abt      = 0;
   int unsigned m_abt_edge = 0;

   function automatic int unsigned fin_edge();
      return m_abt ? m_abt_edge : (m_acc + m_n + 1);
   endfunction

   // 0 = idle, 1 = running, 2 = done, as seen after edge e
   function automatic int ph_at(input int unsigned e);
      if (!m_have) return 0;
      if (e >= fin_edge()) return 2;
      return 1;
   endfunction

   function automatic int unsigned el_at(input int unsigned e);
      if (!m_have) return 0;
      if (e >= fin_edge()) return m_abt ? (m_abt_edge - 1 - m_acc) : m_n;
      return e - m_acc;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b1;
         m_have  <= 1'b0;
         m_abt   <= 1'b0;
      end else if (m_valid) begin
         if (ph_at(edge_cnt) != 1 && bus.iStart) begin
            m_have <= 1'b1;
            m_acc  <= edge_cnt + 1;
            m_n    <= int'(bus.iNumOfData);
            m_abt  <= 1'b0;
         end else if (ph_at(edge_cnt) == 1 && bus.iAbort) begin
            m_abt      <= 1'b1;
            m_abt_edge <= edge_cnt + 1;
         end
      end
      edge_cnt <= edge_cnt + 1;
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_ready", bus.oReady,    ph_at(edge_cnt) != 1);
         chk("model_busy",  bus.oBusy,     ph_at(edge_cnt) == 1);
         chk("model_last",  bus.oLastStep, ph_at(edge_cnt) == 2);
         chk("model_elap",  bus.oElapsed,  el_at(edge_cnt));
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst            = 1'b1;
      bus.iStart     = 1'b0;
      bus.iAbort     = 1'b0;
      bus.iNumOfData = '0;
      repeat (2) step();
      chk("rst_ready", bus.oReady, 1);
      chk("rst_busy",  bus.oBusy, 0);
      chk("rst_last",  bus.oLastStep, 0);
      chk("rst_elap",  bus.oElapsed, 0);
      rst = 1'b0;

      // N = 5
      bus.iStart = 1'b1; bus.iNumOfData = 16'd5;
      step();
      chk("n5_busy_e0", bus.oBusy, 1);
      bus.iStart = 1'b0;
      repeat (5) step();
      chk("n5_busy_e5", bus.oBusy, 1);
      chk("n5_last_e5", bus.oLastStep, 0);
      step();
      chk("n5_last_e6", bus.oLastStep, 1);
      chk("n5_elap",    bus.oElapsed, 5);
      chk("n5_ready",   bus.oReady, 1);

      // N = 0 from DONE
      bus.iStart = 1'b1; bus.iNumOfData = 16'd0;
      step();
      chk("n0_busy_e0", bus.oBusy, 1);
      chk("n0_last_e0", bus.oLastStep, 0);
      bus.iStart = 1'b0;
      step();
      chk("n0_last_e1", bus.oLastStep, 1);
      chk("n0_elap",    bus.oElapsed, 0);

      // Start and abort together in DONE: command wins
      bus.iStart = 1'b1; bus.iAbort = 1'b1; bus.iNumOfData = 16'd3;
      step();
      chk("sa_last_a0", bus.oLastStep, 0);
      chk("sa_busy_a0", bus.oBusy, 1);
      bus.iStart = 1'b0; bus.iAbort = 1'b0;
      repeat (3) step();
      chk("sa_last_a3", bus.oLastStep, 0);
      step();
      chk("sa_last_a4", bus.oLastStep, 1);
      chk("sa_elap",    bus.oElapsed, 3);

      // Abort mid-wait
      bus.iStart = 1'b1; bus.iNumOfData = 16'd100;
      step();
      bus.iStart = 1'b0;
      repeat (20) step();
      bus.iAbort = 1'b1;
      step();
      chk("ab_last", bus.oLastStep, 1);
      chk("ab_busy", bus.oBusy, 0);
      chk("ab_elap", bus.oElapsed, 20);
      bus.iAbort = 1'b0;

      // Reset mid-wait
      bus.iStart = 1'b1; bus.iNumOfData = 16'd50;
      step();
      bus.iStart = 1'b0;
      repeat (10) step();
      rst = 1'b1;
      step();
      chk("mr_ready", bus.oReady, 1);
      chk("mr_busy",  bus.oBusy, 0);
      chk("mr_last",  bus.oLastStep, 0);
      chk("mr_elap",  bus.oElapsed, 0);
      rst = 1'b0;
      repeat (60) step();
      chk("mr_last_late", bus.oLastStep, 0);

      // Long wait with start held high throughout
      bus.iStart = 1'b1; bus.iNumOfData = 16'd11000;
      step();
      repeat (11000) step();
      chk("lg_last_e11000", bus.oLastStep, 0);
      chk("lg_busy_e11000", bus.oBusy, 1);
      step();
      chk("lg_last_e11001", bus.oLastStep, 1);
      chk("lg_elap",        bus.oElapsed, 11000);
      step();
      chk("lg_reacc_last",  bus.oLastStep, 0);
      chk("lg_reacc_elap",  bus.oElapsed, 0);
      bus.iStart = 1'b0; bus.iAbort = 1'b1;
      step();
      bus.iAbort = 1'b0;
      chk("lg_abort_last", bus.oLastStep, 1);
      chk("lg_abort_elap", bus.oElapsed, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst            = ($urandom_range(0, 99) == 0);
         bus.iStart     = ($urandom_range(0, 3) == 0);
         bus.iAbort     = ($urandom_range(0, 15) == 0);
         bus.iNumOfData = DW'($urandom_range(0, 12));
         step();
      end
      rst = 1'b0; bus.iStart = 1'b0; bus.iAbort = 1'b0;
      repeat (20) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
